// File: rtl/bram_scale_ctrl_pkg.sv
// Shared types and constants for the frame-BRAM scale sequencer.
// Optional ones counter is enabled with BRAM_CTRL_PIXCNT_EN (see top).
package bram_scale_pkg;

    localparam int unsigned IMG_W_DEF   = 640;
    localparam int unsigned IMG_H_DEF   = 480;
    localparam int unsigned ADDR_W_DEF  = 19;
    localparam int unsigned SCALE_W_DEF = 4;
    localparam int unsigned SCALE_MIN   = 1;
    localparam int unsigned SCALE_MAX   = 8;
    localparam int unsigned FLUSH_LEN   = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SCAN,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    function automatic logic scale_legal(input int unsigned s);
        return (s >= SCALE_MIN) && (s <= SCALE_MAX);
    endfunction

endpackage

// File: rtl/bram_scale_ctrl_if.sv
// BRAM-side bus of the scale sequencer: write path, scaled read path and flush handshake.
interface bram_scale_ctrl_if
    import bram_scale_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              bram_rst;
    logic              bram_wr_en;
    logic              bram_data_in;
    logic [ADDR_W-1:0] bram_addr_scale;
    logic              bram_end_scale;
    logic              bram_data_out;
    logic              bram_ram_full;
    logic              bram_finish;

    modport master (
        output bram_rst, bram_wr_en, bram_data_in, bram_addr_scale, bram_end_scale,
        input  bram_data_out, bram_ram_full, bram_finish
    );

    modport slave (
        input  bram_rst, bram_wr_en, bram_data_in, bram_addr_scale, bram_end_scale,
        output bram_data_out, bram_ram_full, bram_finish
    );
endinterface

// File: rtl/bram_scale_ctrl_scale_addr_gen.sv
// Decimated raster walker: row_base + x addressing with end-of-line / end-of-frame flags.
module scale_addr_gen
    import bram_scale_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SCALE_W = SCALE_W_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic               step,
    input  logic [SCALE_W-1:0] scale,
    output logic [ADDR_W-1:0]  addr,
    output logic               eol,
    output logic               eof
);
    typedef logic [ADDR_W:0] pos_t;

    localparam pos_t W_P = pos_t'(IMG_W);
    localparam pos_t H_P = pos_t'(IMG_H);

    pos_t x_q, y_q, rb_q, row_step_q;
    pos_t s_p, row_step_d;

    assign s_p = pos_t'(scale);

    // IMG_W * scale as a constant shift-and-add; only evaluated once per frame at init.
    always_comb begin
        row_step_d = '0;
        for (int unsigned i = 0; i < SCALE_W; i++) begin
            if (scale[i]) row_step_d = row_step_d + (W_P << i);
        end
    end

    assign eol  = (x_q + s_p) >= W_P;
    assign eof  = eol && ((y_q + s_p) >= H_P);
    assign addr = ADDR_W'(rb_q + x_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            rb_q       <= '0;
            row_step_q <= '0;
        end else if (init) begin
            x_q        <= '0;
            y_q        <= '0;
            rb_q       <= '0;
            row_step_q <= row_step_d;
        end else if (step) begin
            if (eol) begin
                x_q  <= '0;
                y_q  <= y_q + s_p;
                rb_q <= rb_q + row_step_q;
            end else begin
                x_q  <= x_q + s_p;
            end
        end
    end

endmodule

// File: rtl/bram_scale_ctrl.sv
// Frame BRAM sequencer: load, decimated ready/valid readout, end-of-scale flush.
// Define BRAM_CTRL_PIXCNT_EN to add the ones_cnt output.
module bram_scale_ctrl
    import bram_scale_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SCALE_W = SCALE_W_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCALE_W-1:0] scale,
    input  logic               pix_in_valid,
    input  logic               pix_in,
    output logic               pix_in_ready,
    bram_scale_ctrl_if.master  bram,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_pixel,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               done,
`ifdef BRAM_CTRL_PIXCNT_EN
    output logic               err_scale,
    output logic [ADDR_W-1:0]  ones_cnt
`else
    output logic               err_scale
`endif
);
    state_t             state_q, state_d;
    logic [SCALE_W-1:0] scale_q;
    logic               ov_q, eol_q, eof_q, err_q;
    logic [ADDR_W-1:0]  last_addr_q;
    logic               legal, advance;
    logic               gen_init, gen_step;
    logic [ADDR_W-1:0]  g_addr;
    logic               g_eol, g_eof;
    logic               rst_c, wr_en_c, end_scale_c;

    assign legal   = scale_legal(32'(scale));
    assign advance = !ov_q || out_ready;

    scale_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .ADDR_W  (ADDR_W),
        .SCALE_W (SCALE_W)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (gen_init),
        .step  (gen_step),
        .scale (scale_q),
        .addr  (g_addr),
        .eol   (g_eol),
        .eof   (g_eof)
    );

    always_comb begin
        state_d      = state_q;
        rst_c        = 1'b0;
        wr_en_c      = 1'b0;
        end_scale_c  = 1'b0;
        pix_in_ready = 1'b0;
        done         = 1'b0;
        gen_init     = 1'b0;
        gen_step     = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start && legal) state_d = ST_CLEAR;
            ST_CLEAR: begin
                rst_c    = 1'b1;
                gen_init = 1'b1;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                pix_in_ready = !bram.bram_ram_full;
                wr_en_c      = pix_in_valid && !bram.bram_ram_full;
                if (bram.bram_ram_full) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (advance) begin
                    gen_step = !g_eof;
                    if (g_eof) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (ov_q && out_ready) state_d = ST_FLUSH;
            ST_FLUSH: begin
                end_scale_c = !bram.bram_finish;
                if (bram.bram_finish) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A stalled beat re-presents its own address so the 1-cycle BRAM keeps returning the same pixel.
    assign bram.bram_addr_scale = (ov_q && !out_ready) ? last_addr_q : g_addr;
    assign bram.bram_rst        = rst_c;
    assign bram.bram_wr_en      = wr_en_c;
    assign bram.bram_data_in    = (state_q == ST_LOAD) && pix_in;
    assign bram.bram_end_scale  = end_scale_c;

    assign out_valid = ov_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign out_pixel = bram.bram_data_out;
    assign busy      = (state_q != ST_IDLE);
    assign err_scale = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            scale_q     <= '0;
            ov_q        <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ST_IDLE) && start && !legal;
            if ((state_q == ST_IDLE) && start && legal) scale_q <= scale;
            if (state_q == ST_SCAN) begin
                if (advance) begin
                    ov_q        <= 1'b1;
                    eol_q       <= g_eol;
                    eof_q       <= g_eof;
                    last_addr_q <= g_addr;
                end
            end else if (!((state_q == ST_DRAIN) && !out_ready)) begin
                ov_q  <= 1'b0;
                eol_q <= 1'b0;
                eof_q <= 1'b0;
            end
        end
    end

`ifdef BRAM_CTRL_PIXCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (state_q == ST_CLEAR) begin
            ones_cnt <= '0;
        end else if (ov_q && out_ready && bram.bram_data_out) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_scale_ctrl.sv
// Bench for bram_scale_ctrl on a reduced 20x14 frame with a behavioural BRAM model.
module tb_bram_scale_ctrl;
    import bram_scale_pkg::*;

    localparam int W  = 20;
    localparam int H  = 14;
    localparam int N  = W * H;
    localparam int AW = 9;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] scale = '0;
    logic          pix_in_valid = 1'b0;
    logic          pix_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          pix_in_ready, out_valid, out_pixel, out_eol, out_eof;
    logic          busy, done, err_scale;
`ifdef BRAM_CTRL_PIXCNT_EN
    logic [AW-1:0] ones_cnt;
`endif

    bram_scale_ctrl_if #(.ADDR_W(AW)) bram_bus ();

    bram_scale_ctrl #(
        .IMG_W   (W),
        .IMG_H   (H),
        .ADDR_W  (AW),
        .SCALE_W (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .scale        (scale),
        .pix_in_valid (pix_in_valid),
        .pix_in       (pix_in),
        .pix_in_ready (pix_in_ready),
        .bram         (bram_bus.master),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_eol      (out_eol),
        .out_eof      (out_eof),
        .busy         (busy),
        .done         (done),
`ifdef BRAM_CTRL_PIXCNT_EN
        .err_scale    (err_scale),
        .ones_cnt     (ones_cnt)
`else
        .err_scale    (err_scale)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model: write counter, full flag, 1-cycle read, flush counter.
    logic          mem [N];
    logic [AW-1:0] wcnt;
    int unsigned   fcnt;
    logic          rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            fcnt <= 0;
        end else if (bram_bus.bram_rst) begin
            wcnt <= '0;
            fcnt <= 0;
        end else begin
            if (bram_bus.bram_wr_en) begin
                mem[wcnt] <= bram_bus.bram_data_in;
                wcnt      <= wcnt + 1'b1;
            end
            if (bram_bus.bram_end_scale) fcnt <= fcnt + 1;
        end
    end

    always @(posedge clk) rd <= (int'(bram_bus.bram_addr_scale) < N) ? mem[bram_bus.bram_addr_scale] : 1'b0;

    assign bram_bus.bram_data_out = rd;
    assign bram_bus.bram_ram_full = (int'(wcnt) == N);
    assign bram_bus.bram_finish   = (fcnt >= FLUSH_LEN);

    typedef struct packed {
        logic pix;
        logic eol;
        logic eof;
    } exp_t;

    typedef struct {
        int unsigned scale;
        int unsigned pat;
        int unsigned rmode;
        int unsigned exp_beats;
        int unsigned exp_rows;
    } vec_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rmode = 0;
    int unsigned beats, rows, eofs, ones_seen;
    int unsigned wr_full_viol = 0;
    int unsigned rdy_full_viol = 0;
    int          cyc = 0;
    int          eof_cyc, done_cyc;
    logic        done_seen;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, full-flag protection, done timing.
    initial begin
        logic prev_stall;
        logic [2:0] prev_v, cur_v;
        exp_t e;
        prev_stall = 1'b0;
        prev_v     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                cur_v = {out_pixel, out_eol, out_eof};
                if (bram_bus.bram_wr_en && bram_bus.bram_ram_full) wr_full_viol++;
                if (pix_in_ready && bram_bus.bram_ram_full) rdy_full_viol++;
                if (out_valid && prev_stall) check("stall_hold", 32'(cur_v), 32'(prev_v));
                if (out_valid && out_ready) begin
                    beats++;
                    if (out_eol) rows++;
                    if (out_eof) begin
                        eofs++;
                        eof_cyc = cyc;
                    end
                    if (out_pixel) ones_seen++;
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("pixel", 32'(cur_v), 32'(e));
                    end
                end
                if (done) begin
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_v     = cur_v;
            end
        end
    end

    task automatic run_frame(input int unsigned s, input int unsigned pat, input int unsigned rm,
                             input int unsigned exp_beats, input int unsigned exp_rows,
                             input int unsigned abort_at);
        logic        src [N];
        exp_t        e;
        int unsigned exp_ones, i, budget;
        exp_ones  = 0;
        sb.delete();
        beats     = 0;
        rows      = 0;
        eofs      = 0;
        ones_seen = 0;
        done_seen = 1'b0;
        for (int p = 0; p < N; p++) begin
            case (pat)
                0:       src[p] = 1'($urandom_range(0, 1));
                1:       src[p] = 1'(((p % W) + (p / W)) % 2);
                default: src[p] = 1'b1;
            endcase
        end
        for (int yy = 0; yy < H; yy += int'(s)) begin
            for (int xx = 0; xx < W; xx += int'(s)) begin
                e.pix = src[yy * W + xx];
                e.eol = (xx == ((W - 1) / int'(s)) * int'(s));
                e.eof = e.eol && (yy == ((H - 1) / int'(s)) * int'(s));
                sb.push_back(e);
                exp_ones += 32'(e.pix);
            end
        end
        rmode = rm;
        @(posedge clk);
        #1 start = 1'b1;
        scale = SW'(s);
        @(posedge clk);
        #1 start = 1'b0;
        i      = 0;
        budget = 0;
        while (i < N && budget < 4 * N) begin
            pix_in_valid = ($urandom_range(0, 3) != 0);
            pix_in       = src[i];
            @(negedge clk);
            if (pix_in_valid && pix_in_ready) i++;
            @(posedge clk);
            #1;
            budget++;
        end
        check("load_count", i, N);
        pix_in_valid = 1'b1;
        pix_in       = 1'($urandom_range(0, 1));
        if (abort_at != 0) begin
            budget = 0;
            while (beats < abort_at && budget < 8 * N) begin
                @(negedge clk);
                budget++;
            end
            check("abort_reached", 32'(beats >= abort_at), 1);
            rst_n = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 0);
            check("abort_valid", 32'({out_valid, out_eol, out_eof}), 0);
            check("abort_bram", 32'({bram_bus.bram_rst, bram_bus.bram_wr_en, bram_bus.bram_end_scale}), 0);
            check("abort_addr", 32'(bram_bus.bram_addr_scale), 0);
            check("abort_misc", 32'({pix_in_ready, done, err_scale}), 0);
            pix_in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            sb.delete();
        end else begin
            budget = 0;
            while (!done_seen && budget < 8 * N) begin
                @(posedge clk);
                budget++;
            end
            pix_in_valid = 1'b0;
            check("done_seen", 32'(done_seen), 1);
            check("beats", beats, exp_beats);
            check("rows", rows, exp_rows);
            check("eof_count", eofs, 1);
            check("sb_left", sb.size(), 0);
            check("done_latency", 32'((done_cyc - eof_cyc >= int'(FLUSH_LEN)) &&
                                      (done_cyc - eof_cyc <= int'(FLUSH_LEN) + 1)), 1);
            check("ones_seen", ones_seen, exp_ones);
            @(negedge clk);
            check("busy_after_done", 32'(busy), 0);
            check("done_pulse", 32'(done), 0);
`ifdef BRAM_CTRL_PIXCNT_EN
            check("ones_cnt", 32'(ones_cnt), exp_ones);
`endif
        end
    endtask

    initial begin
        vec_t        vecs [6];
        logic [SW-1:0] bad [3];
        vecs[0] = '{scale: 2, pat: 0, rmode: 0, exp_beats: 70,  exp_rows: 7};
        vecs[1] = '{scale: 3, pat: 1, rmode: 0, exp_beats: 35,  exp_rows: 5};
        vecs[2] = '{scale: 1, pat: 0, rmode: 1, exp_beats: 280, exp_rows: 14};
        vecs[3] = '{scale: 8, pat: 0, rmode: 2, exp_beats: 6,   exp_rows: 2};
        vecs[4] = '{scale: 5, pat: 2, rmode: 2, exp_beats: 12,  exp_rows: 3};
        vecs[5] = '{scale: 4, pat: 0, rmode: 2, exp_beats: 20,  exp_rows: 4};
        bad[0] = 4'd0;
        bad[1] = 4'd9;
        bad[2] = 4'd15;

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'({out_valid, out_eol, out_eof}), 0);
        check("reset_bram", 32'({bram_bus.bram_rst, bram_bus.bram_wr_en, bram_bus.bram_end_scale}), 0);
        check("reset_addr", 32'(bram_bus.bram_addr_scale), 0);
        check("reset_misc", 32'({pix_in_ready, done, err_scale}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 start = 1'b1;
            scale = bad[k];
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("err_pulse", 32'(err_scale), 1);
            check("err_busy", 32'(busy), 0);
            check("err_bram_rst", 32'(bram_bus.bram_rst), 0);
            @(negedge clk);
            check("err_one_cycle", 32'(err_scale), 0);
            check("err_still_idle", 32'(busy), 0);
        end

        for (int k = 0; k < 6; k++) begin
            run_frame(vecs[k].scale, vecs[k].pat, vecs[k].rmode,
                      vecs[k].exp_beats, vecs[k].exp_rows, 0);
        end

        run_frame(2, 0, 0, 0, 0, 30);
        run_frame(4, 1, 1, 20, 4, 0);

        check("wr_en_while_full", wr_full_viol, 0);
        check("ready_while_full", rdy_full_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_scale_ctrl.md
Name: bram_scale_ctrl

Overview:
Sequencer for the 1-bit 640x480 frame BRAM (single write/read address mux, 307200 entries, 20-cycle end-of-scale flush).
- Loads one binary frame from an upstream pixel stream.
- Reads the frame back decimated by an integer factor, as a ready/valid pixel stream with end-of-line and end-of-frame flags.
- Then drives the BRAM end-of-scale flush and reports completion.
- Sits between the binarisation stage and the downstream scaled-window consumer.

Parameters:
IMG_W, 640, frame width in pixels
IMG_H, 480, frame height in pixels
ADDR_W, 19, BRAM address width (must satisfy 2^ADDR_W > IMG_W*IMG_H)
SCALE_W, 4, width of the scale input

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a frame; accepted only in IDLE
scale  in  SCALE_W  decimation factor; legal 1..8; sampled with start
pix_in_valid  in  1  upstream pixel valid
pix_in  in  1  upstream binary pixel
pix_in_ready  out  1  controller accepts pix_in this cycle
bram_rst  out  1  active-high synchronous clear to BRAM (write counter, flush counter)
bram_wr_en  out  1  BRAM write enable / address-mux select
bram_data_in  out  1  BRAM write data
bram_addr_scale  out  ADDR_W  BRAM read address
bram_end_scale  out  1  BRAM end-of-scale flush request
bram_data_out  in  1  BRAM read data (1-cycle latency from address)
bram_ram_full  in  1  BRAM write counter has reached IMG_W*IMG_H
bram_finish  in  1  BRAM flush complete
out_valid  out  1  scaled pixel valid
out_ready  in  1  downstream accepts out_pixel
out_pixel  out  1  scaled pixel (combinational from bram_data_out)
out_eol  out  1  qualifies out_valid: last pixel of output row
out_eof  out  1  qualifies out_valid: last pixel of frame
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on FLUSH->IDLE
err_scale  out  1  one-cycle pulse when start is given with scale 0 or >8

Behaviour:
- Reset: all outputs 0 and state IDLE; bram_addr_scale=0. Reset asserted mid-frame aborts immediately; no resume.
- FSM states: IDLE, CLEAR, LOAD, SCAN, DRAIN, FLUSH.
- IDLE:
  - start with legal scale: latch scale into scale_q, go to CLEAR.
  - start with illegal scale: err_scale pulse, stay IDLE.
  - start in any other state is ignored.
- CLEAR (1 cycle): bram_rst=1, bram_wr_en=0, then go to LOAD.
- LOAD:
  - pix_in_ready = !bram_ram_full.
  - bram_wr_en = pix_in_valid & !bram_ram_full; bram_data_in = pix_in.
  - Never assert bram_wr_en while bram_ram_full=1, so no write lands at index IMG_W*IMG_H.
  - bram_ram_full=1: go to SCAN with x=0, y=0, row_base=0.
- SCAN (bram_wr_en=0):
  - bram_addr_scale = row_base + x. No multiplier; row_base advances by IMG_W*scale_q.
  - Address advances when !out_valid | out_ready; otherwise it is held, so the BRAM re-reads the same pixel.
  - out_valid, out_eol and out_eof are registered one cycle behind the address. First out_valid comes 1 cycle after SCAN entry.
  - Column step: x += scale_q. eol when x+scale_q >= IMG_W; then x=0, y += scale_q.
  - eof when eol and y+scale_q >= IMG_H; the address stops and the FSM goes to DRAIN.
  - Output size: ceil(IMG_W/s) x ceil(IMG_H/s).
  - Internal x/y/row_base widths: ADDR_W+1 bits, so they never overflow.
- DRAIN: hold until the eof pixel is accepted (out_valid & out_ready), then FLUSH.
- FLUSH:
  - bram_end_scale=1 until bram_finish=1; 20 cycles with the current BRAM.
  - Then done=1 for one cycle and return to IDLE.
  - bram_end_scale is deasserted in the same cycle bram_finish is seen.
- out_pixel = bram_data_out without gating. out_valid is 0 in every state other than SCAN/DRAIN.

Optional Feature:
BRAM_CTRL_PIXCNT_EN
- Defined: adds output ones_cnt [ADDR_W-1:0], counting accepted output pixels equal to 1.
  - Cleared in CLEAR.
  - Increments on out_valid & out_ready & out_pixel.
  - Frozen after done, until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package bram_scale_pkg:
  - state enum.
  - IMG_W/IMG_H defaults.
  - SCALE_MIN=1, SCALE_MAX=8.
  - FLUSH_LEN=20 (used by the bench only).
- One natural sub-module, scale_addr_gen: x/y/row_base stepping, eol/eof flags, hold on stall. FSM and BRAM handshakes stay in the top.

Test Plan:
- scale=2, continuous pix_in_valid, out_ready=1 -> LOAD lasts 307200 cycles; 76800 out_valid beats; 240 eol; single eof on pixel (478,638); done 20-21 cycles after eof.
- scale=3 with a checkerboard frame -> 214x160 outputs; every pixel equals source[y*640+x] for x,y multiples of 3; last address 477*640+639.
- scale=1 with out_ready toggled 1/0 every cycle -> 307200 pixels, exact frame copy; out_pixel is stable while stalled.
- start with scale=0, then scale=9 -> err_scale pulses twice; busy stays 0; no bram_rst.
- rst_n pulled low in mid-SCAN (after 1000 beats), then new start with scale=4 -> all outputs 0 immediately; second frame yields 160x120 correct pixels.
- pix_in_valid held high after full -> bram_wr_en never high while bram_ram_full=1; pix_in_ready=0.
